// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle unsigned restoring divider. It captures an 8-bit dividend and a
//   4-bit divisor on an accepted start and produces one quotient bit per clock.
//   It returns quotient = floor(dividend/divisor) and
//   remainder = dividend mod divisor.
//
//   Handshake (valid/ready style):
//     - start is the request and is sampled on a rising clk edge.
//     - A start is accepted whenever busy is low (IDLE or DONE state).
//     - A start seen while busy is ignored, and the operands are not captured.
//     - done pulses for one cycle when quotient/remainder/div_by_zero are valid.
//     - The results then hold until the next accepted start.
//     - A start held high during the done cycle is accepted back-to-back.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        division request
//   dividend     DW-bit unsigned dividend, captured on accept
//   divisor      VW-bit unsigned divisor, captured on accept
//   busy         high while quotient bits are being produced
//   done         one-cycle result-valid pulse
//   div_by_zero  set with done when the captured divisor was 0
//   quotient     DW-bit unsigned quotient (all ones on divide by zero)
//   remainder    VW-bit unsigned remainder (0 on divide by zero)
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic          div_by_zero,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  // quo_q starts out holding the dividend. Each iteration shifts the dividend
  // MSB out into the partial remainder and shifts the new quotient bit in at
  // the LSB. After DW iterations it holds only quotient bits.
  logic [DW-1:0] quo_q, quo_d;
  logic [VW:0]   prem_q, prem_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbz_q, dbz_d;

  logic          accept;
  logic [VW+1:0] shifted;
  logic [VW+1:0] trial;

  // A new operation may start from IDLE or straight out of DONE.
  assign accept = start && (state_q != CALC);

  // The partial remainder is always below the divisor between iterations, so
  // prem_q[VW] is 0. The shifted value therefore fits in VW+1 bits. The extra
  // top bit of trial is the borrow, which tells us the subtraction went
  // negative.
  assign shifted = {prem_q, quo_q[DW-1]};
  assign trial   = shifted - {2'b00, dvs_q};

  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    prem_d  = prem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;

    if (accept) begin
      dvs_d = divisor;
      if (divisor == '0) begin
        state_d = DONE;
        quo_d   = '1;
        prem_d  = '0;
        cnt_d   = '0;
        dbz_d   = 1'b1;
      end else begin
        state_d = CALC;
        quo_d   = dividend;
        prem_d  = '0;
        cnt_d   = CW'(DW);
        dbz_d   = 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        CALC: begin
          if (trial[VW+1]) begin
            // Negative: restore, i.e. keep the shifted value, quotient bit 0.
            prem_d = shifted[VW:0];
            quo_d  = {quo_q[DW-2:0], 1'b0};
          end else begin
            prem_d = trial[VW:0];
            quo_d  = {quo_q[DW-2:0], 1'b1};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      quo_q   <= '0;
      prem_q  <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      prem_q  <= prem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign quotient    = quo_q;
  assign remainder   = prem_q[VW-1:0];

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Directed and randomized checks of seq_divider. Expected values come from
//   plain integer division and modulo, held in an expected queue and popped
//   when done is seen.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int DW = 8;
  localparam int VW = 4;
  localparam int EW = 1 + DW + VW;  // {div_by_zero, quotient, remainder}

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  int total;
  int bad;
  logic [EW-1:0] exp_q[$];

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  // Clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arithmetic on integers.
  function automatic logic [EW-1:0] model(input int a, input int b);
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    if (b == 0) begin
      q = '1;
      r = '0;
      return {1'b1, q, r};
    end
    q = DW'(a / b);
    r = VW'(a % b);
    return {1'b0, q, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive a start for one edge. Returns at the first negedge after the
  // accepting edge.
  task automatic launch(input int a, input int b);
    @(negedge clk);
    start    = 1'b1;
    dividend = DW'(a);
    divisor  = VW'(b);
    @(negedge clk);
    start    = 1'b0;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
  endtask

  // Counts busy cycles until done is seen, with a cycle budget.
  task automatic wait_done(output int lat, output bit timed_out);
    int n;
    lat = 0;
    n   = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) lat++;
      @(negedge clk);
      n++;
    end
    timed_out = (done !== 1'b1);
  endtask

  // Compare results at the done cycle against the head of exp_q.
  task automatic check_result(input string tag, input int lat, input int exp_lat);
    logic [EW-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk({tag, ".quotient"},  32'(quotient),    32'(e[DW+VW-1:VW]));
    chk({tag, ".remainder"}, 32'(remainder),   32'(e[VW-1:0]));
    chk({tag, ".dbz"},       32'(div_by_zero), 32'(e[EW-1]));
    chk({tag, ".latency"},   32'(lat),         32'(exp_lat));
    chk({tag, ".busy_at_done"}, 32'(busy),     32'd0);
  endtask

  // One full division: launch, wait, check, then confirm the done pulse ends.
  task automatic run_op(input string tag, input int a, input int b);
    int lat;
    bit to;
    exp_q.push_back(model(a, b));
    launch(a, b);
    wait_done(lat, to);
    chk({tag, ".timeout"}, 32'(to), 32'd0);
    check_result(tag, lat, (b == 0) ? 0 : DW);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    bit to;
    int a;
    int b;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    // Reset state
    repeat (3) begin
      @(negedge clk);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.quotient", 32'(quotient), 32'd0);
      chk("rst.remainder", 32'(remainder), 32'd0);
      chk("rst.dbz", 32'(div_by_zero), 32'd0);
    end
    rst_n = 1'b1;

    run_op("d200_7", 200, 7);
    run_op("d255_15", 255, 15);
    run_op("d255_1", 255, 1);
    run_op("d5_9", 5, 9);
    run_op("d0_3", 0, 3);
    run_op("d123_0", 123, 0);
    run_op("d100_10", 100, 10);

    // Start while busy is ignored; start held through DONE is accepted.
    exp_q.push_back(model(200, 7));
    exp_q.push_back(model(50, 3));
    launch(200, 7);
    repeat (2) @(negedge clk);
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 4'd3;
    wait_done(lat, to);
    chk("busy_start.timeout", 32'(to), 32'd0);
    check_result("busy_start", lat + 2, DW);
    @(negedge clk);
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    wait_done(lat, to);
    chk("b2b.timeout", 32'(to), 32'd0);
    check_result("b2b", lat, DW);
    @(negedge clk);
    chk("b2b.done_pulse", 32'(done), 32'd0);

    // Reset during CALC: outputs clear at once, no done pulse afterwards.
    launch(200, 7);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.quotient", 32'(quotient), 32'd0);
    chk("midrst.remainder", 32'(remainder), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst.no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("midrst.after_release", 32'(done | busy), 32'd0);
    end
    run_op("d9_2", 9, 2);

    // Randomized operations including divide by zero, with random idle gaps.
    repeat (300) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op("rand", a, b);
    end

    // Full sweep of non-zero divisors, visited in a random rotation.
    for (int bi = 1; bi <= 15; bi++) begin
      int off;
      off = int'($urandom_range(0, 255));
      for (int ai = 0; ai < 256; ai++) begin
        run_op("sweep", (ai + off) % 256, bi);
      end
    end

    chk("exp_q.empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
